// File: rtl/ram_port_arbiter.sv
// Two-client arbiter/sequencer for the 16x8 dual-port RAM: one operation in flight, registered RAM controls and response.
// Build option: define RAM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise client 0 has fixed priority.
module ram_port_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_re,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e            state_q;
  logic              id_q;
  logic              write_q;
  logic [1:0]        resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              mem_re_q;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_raddr_q;
  logic [ADDR_W-1:0] mem_waddr_q;
  logic [DATA_W-1:0] mem_din_q;

  logic              grant_s;
  logic              hs_s;
  logic              write_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last_q;
`endif

  // Winner selection among valid requesters
  always_comb begin
    grant_s = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    if (req_valid == 2'b11) begin
      grant_s = ~last_q;
    end else if (req_valid[0]) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
`else
    if (req_valid[0]) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
`endif
  end

  // Handshake only from IDLE and never while reset is being applied
  assign hs_s = (state_q == IDLE) && !rst && (req_valid != 2'b00);

  // Ready is combinational so a request is accepted in its first IDLE cycle
  always_comb begin
    req_ready = 2'b00;
    if (hs_s) begin
      req_ready = grant_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
  end

  // Mux of the winning client's request fields
  always_comb begin
    write_d = req_write[0];
    addr_d  = req_addr0;
    wdata_d = req_wdata0;
    if (grant_s) begin
      write_d = req_write[1];
      addr_d  = req_addr1;
      wdata_d = req_wdata1;
    end else begin
      write_d = req_write[0];
      addr_d  = req_addr0;
      wdata_d = req_wdata0;
    end
  end

  // Sequencer FSM with registered RAM controls and response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      id_q         <= 1'b0;
      write_q      <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_rdata_q <= {DATA_W{1'b0}};
      mem_re_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_raddr_q  <= {ADDR_W{1'b0}};
      mem_waddr_q  <= {ADDR_W{1'b0}};
      mem_din_q    <= {DATA_W{1'b0}};
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_q       <= 1'b1;
`endif
    end else begin
      mem_re_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      resp_valid_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (hs_s) begin
            id_q     <= grant_s;
            write_q  <= write_d;
            mem_re_q <= ~write_d;
            mem_wr_q <= write_d;
            if (write_d) begin
              mem_waddr_q <= addr_d;
              mem_din_q   <= wdata_d;
            end else begin
              mem_raddr_q <= addr_d;
            end
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_q   <= grant_s;
`endif
            state_q  <= ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          if (write_q) begin
            resp_valid_q <= id_q ? 2'b10 : 2'b01;
            state_q      <= DONE;
          end else begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          // RAM output is only meaningful this cycle, so it is held here
          resp_rdata_q <= mem_dout;
          resp_valid_q <= id_q ? 2'b10 : 2'b01;
          state_q      <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_re     = mem_re_q;
  assign mem_wr     = mem_wr_q;
  assign mem_raddr  = mem_raddr_q;
  assign mem_waddr  = mem_waddr_q;
  assign mem_din    = mem_din_q;

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-client arbiter and sequencer for the 16x8 dual-port RAM. It accepts read/write requests from two independent requesters over a valid/ready handshake and grants one at a time. It drives the RAM's re/wr/address/data pins with a legal single-operation sequence, captures the registered read data, and returns a one-cycle response pulse to the granted client. It sits directly between the RAM instance and its two users, and is the only block allowed to drive the RAM control pins.

## Interface
Parameters:
- ADDR_W, 4, RAM address width (16 words)
- DATA_W, 8, RAM data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  2  per-client request valid, bit k = client k
- req_write  in  2  per-client op: 1 = write, 0 = read
- req_addr0 / req_addr1  in  ADDR_W  client address
- req_wdata0 / req_wdata1  in  DATA_W  client write data
- req_ready  out  2  handshake accept; at most one bit set
- resp_valid  out  2  one-cycle completion pulse to the granted client
- resp_rdata  out  DATA_W  read data, valid while resp_valid is set for a read
- mem_re  out  1  RAM read enable
- mem_wr  out  1  RAM write enable
- mem_raddr  out  ADDR_W  RAM read address
- mem_waddr  out  ADDR_W  RAM write address
- mem_din  out  DATA_W  RAM write data
- mem_dout  in  DATA_W  RAM registered read data

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE:
  - If any req_valid bit is set, the arbiter picks a winner and asserts req_ready for that client only, combinationally in the same cycle.
  - Handshake completes when valid and ready are both high. Latch client id, op, addr and wdata, then go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE: drive exactly one of mem_re or mem_wr high, with the latched address on mem_raddr or mem_waddr (and wdata on mem_din for writes).
  - Read goes to CAPTURE.
  - Write goes to DONE.
- CAPTURE: register mem_dout into resp_rdata. mem_re and mem_wr are both low. Go to DONE.
- DONE: resp_valid[id] = 1 for one cycle, then go to IDLE. A write completion leaves resp_rdata unchanged.
- mem_re and mem_wr are never high in the same cycle. Both are low in every state except ISSUE.
- The RAM output floats when re is low, so resp_rdata is held in a register and never taken directly from mem_dout.
- Requests are not latched until the handshake. A requester may change addr, data or op while valid is high and ready is low.
- req_ready is 0 outside IDLE. No pipelining: one outstanding operation at a time.
- Reset mid-operation: the FSM returns to IDLE and the in-flight request is dropped with no resp_valid. The requester must re-issue it.
- The RAM's own rst is driven from the same system rst by the integrator, not by this block.

## Timing
- Reset values:
  - req_ready = 0, resp_valid = 0, resp_rdata = 0
  - mem_re = 0, mem_wr = 0
  - mem_raddr, mem_waddr and mem_din = 0
  - state = IDLE, last-grant pointer = 1
- Read, with the handshake in cycle t: mem_re high in t+1, capture in t+2, resp_valid in t+3.
- Write, with the handshake in cycle t: mem_wr high in t+1, resp_valid in t+2.
- Throughput: back-to-back handshakes are at least 4 cycles apart for reads and 3 cycles apart for writes. The next IDLE cycle follows DONE.

## Configuration
- RAM_ARB_ROUND_ROBIN_EN defined:
  - When both clients are valid in IDLE, grant the client that was not granted last.
  - The pointer updates on each handshake.
  - After reset, client 0 wins the first tie.
- RAM_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: client 0 always wins a tie.
  - Client 1 is granted only when req_valid[0] = 0.
  - The pointer logic is not compiled.

## Test plan
- Client 0 writes 0xA5 to addr 3, then reads addr 3:
  - Write: mem_wr pulse one cycle after the handshake, resp_valid[0] two cycles after the handshake.
  - Read: resp_valid[0] three cycles after the read handshake with resp_rdata = 0xA5.
- Both clients valid every cycle, with client 0 reading addr 1 and client 1 reading addr 2:
  - With RAM_ARB_ROUND_ROBIN_EN, grants alternate 0,1,0,1.
  - Without it, client 1 is never granted.
- Assert rst in the CAPTURE cycle of a read: no resp_valid, and req_ready = 0 in the reset cycle.
  - In the first IDLE cycle after reset, the client can re-handshake and complete normally.
- Client 1 changes addr from 5 to 9 while valid and not ready (FSM busy): the RAM receives addr 9, the value present at the handshake.
- Every cycle of a 200-op random mixed run:
  - !(mem_re & mem_wr) and |req_ready ≤ 1.
  - resp_rdata for each read matches a reference memory model.
